pfb_deadlock_watchdog_ctrl: RTL and testbench
=============================================

// Module: pfb_deadlock_watchdog_ctrl
// PURPOSE
//  - Supervises the HLS dataflow deadlock monitors of the PFB multichannel decimator.
//  - Qualifies raw per-index block flags with a programmable persistence window and snapshots process state.
//  - Reports the event over a valid/ready stream, raises an IRQ and, on software request, pulses a recovery reset.
//  - Sits between the deadlock monitor tree and the control/status register block.
// PARAMETERS
//  - NUM_IDX    3   number of monitor indices (idx0..idxN-1 block flags)
//  - NUM_PROC   3   number of dataflow processes snapshotted
//  - CNT_W      16  width of persistence counter and hold_cycles
//  - RPT_W      32  report word width; must be >= NUM_IDX+2*NUM_PROC
//  - RST_PULSE  16  recovery reset pulse length in cycles (>=1)
// PORTS
//  - clock           in   1         single clock; all logic rising-edge
//  - reset_n         in   1         asynchronous, active-low reset
//  - enable          in   1         watchdog armed when high
//  - idx_block       in   NUM_IDX   per-index block flags from monitors
//  - proc_idle       in   NUM_PROC  process idle flags
//  - proc_chan_block in   NUM_PROC  process channel-block flags
//  - hold_cycles     in   CNT_W     consecutive block cycles required to trip; 0 treated as 1
//  - rpt_valid       out  1         report beat valid
//  - rpt_ready       in   1         report beat accepted
//  - rpt_data        out  RPT_W     report beat
//  - irq             out  1         level interrupt, event pending
//  - clr             in   1         single-cycle acknowledge from software
//  - clr_recover     in   1         sampled with clr; 1 = issue recovery reset
//  - recover_rst     out  1         active-high reset to dataflow region
//  - trip_count      out  8         saturating count of trips since reset
// BEHAVIOUR
//  - Reset (reset_n=0, async): state IDLE; all outputs 0; counter, snapshot and trip_count cleared. Reset mid-operation aborts any report or pulse immediately.
//  - any_blk = |idx_block.
//  - FSM states and transitions:
//    - IDLE: go to ARMED when enable=1.
//    - ARMED: cnt increments while any_blk, clears to 0 on any cycle !any_blk; enable=0 returns to IDLE with cnt=0.
//      Trip occurs in the cycle cnt+1 == max(hold_cycles,1), i.e. after exactly N consecutive block cycles.
//      On the trip edge: snapshot {idx_block,proc_idle,proc_chan_block}, trip_count += 1 (saturates at 255), next state REPORT.
//    - REPORT: rpt_valid=1; rpt_data = zero-padded {idx,idle,chan_block}, idx in MSBs of the used field.
//      Data is stable while valid && !ready; the beat is transferred when valid&&ready.
//      After the last beat: irq=1, go to WAIT_CLR.
//    - WAIT_CLR: irq held; clr=1 with clr_recover=1 -> RECOVER; clr=1 with clr_recover=0 -> IDLE; irq drops the cycle after clr.
//    - RECOVER: recover_rst=1 for exactly RST_PULSE cycles, then IDLE.
//  - Inputs idx_block/proc_* and enable are ignored in REPORT, WAIT_CLR and RECOVER. clr is ignored outside WAIT_CLR.
//  - Counter saturates at all-ones and never wraps. hold_cycles is sampled every cycle in ARMED; a lowered value trips on the next block cycle once cnt+1 >= value.
//  - Latency: trip edge -> rpt_valid is 1 cycle (registered).
// CONFIGURATION
//  - Macro: PFB_DEADLOCK_TIMESTAMP_EN.
//  - Defined: a free-running CNT_W... 32-bit cycle counter (reset to 0, wraps) is captured on the trip edge; the report is 2 beats (beat0 snapshot, beat1 timestamp), and irq asserts after beat1.
//  - Undefined: no counter; the report is a single beat.
// STRUCTURE
//  - Package pfb_deadlock_pkg: FSM state enum (IDLE, ARMED, REPORT, WAIT_CLR, RECOVER); snapshot struct; TRIP_CNT_MAX=255 constant.
//  - Sub-module pfb_deadlock_persist_cnt: the consecutive-cycle counter with clear, saturation and trip-compare output.
// TESTING
//  - Trip: hold_cycles=4, idx_block=3'b010 for 4 cycles -> trip on the 4th cycle; rpt_data[RPT_W-1:0] = {..,010,idle,blk}; trip_count=1.
//  - Glitch: hold_cycles=4, block 3 cycles, 1 low, 3 high -> no trip, rpt_valid stays 0.
//  - Backpressure: rpt_ready=0 for 10 cycles -> rpt_valid and rpt_data stable; irq=0 until the beat is accepted.
//  - Recovery: clr=1, clr_recover=1 in WAIT_CLR, RST_PULSE=16 -> recover_rst high exactly 16 cycles, then IDLE; irq=0.
//  - Boundaries: hold_cycles=0 with a single block cycle -> trip; 300 trips -> trip_count=255; reset_n low during RECOVER -> recover_rst=0 immediately.
//  - With PFB_DEADLOCK_TIMESTAMP_EN: trip at cycle 1000 after reset -> two beats, beat1=1000 (+/- fixed documented offset of 0).

Source files
------------

// File: rtl/pfb_deadlock_pkg.sv
// Shared types and constants for the PFB dataflow deadlock watchdog.
package pfb_deadlock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    REPORT,
    WAIT_CLR,
    RECOVER
  } state_e;

  localparam int SNAP_IDX_W  = 3;
  localparam int SNAP_PROC_W = 3;

  // Field order matches the report word: idx in the MSBs of the used field.
  typedef struct packed {
    logic [SNAP_IDX_W-1:0]  idx_block;
    logic [SNAP_PROC_W-1:0] proc_idle;
    logic [SNAP_PROC_W-1:0] proc_chan_block;
  } snap_t;

  localparam logic [7:0] TRIP_CNT_MAX = 8'd255;

endpackage

// File: rtl/pfb_deadlock_watchdog_ctrl_if.sv
// Report stream between the deadlock watchdog (master) and the CSR block (slave).
interface pfb_deadlock_watchdog_ctrl_if #(
  parameter int RPT_W = 32
);
  logic             rpt_valid;
  logic             rpt_ready;
  logic [RPT_W-1:0] rpt_data;

  modport master (output rpt_valid, output rpt_data, input rpt_ready);
  modport slave  (input rpt_valid, input rpt_data, output rpt_ready);
endinterface

// File: rtl/pfb_deadlock_persist_cnt.sv
// Consecutive block-cycle counter: clears on any idle cycle, saturates, and
// flags a trip once cnt+1 reaches max(hold,1).
module pfb_deadlock_persist_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             active_i,
  input  logic             blk_i,
  input  logic [CNT_W-1:0] hold_i,
  output logic             trip_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] hold_eff;

  always_comb begin
    cnt_inc  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    hold_eff = (hold_i == '0) ? CNT_W'(1) : hold_i;
    // >= rather than == so a lowered hold value trips on the next block cycle
    trip_o   = active_i && blk_i && (cnt_inc >= {1'b0, hold_eff});
    cnt_d    = cnt_q;
    if (!active_i || !blk_i || trip_o) begin
      cnt_d = '0;
    end else if (!cnt_inc[CNT_W]) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pfb_deadlock_watchdog_ctrl.sv
// Deadlock watchdog: qualifies block flags, reports a snapshot, raises IRQ and
// pulses a recovery reset. Optional macro PFB_DEADLOCK_TIMESTAMP_EN adds a timestamp beat.
module pfb_deadlock_watchdog_ctrl
  import pfb_deadlock_pkg::*;
#(
  parameter int NUM_IDX   = 3,
  parameter int NUM_PROC  = 3,
  parameter int CNT_W     = 16,
  parameter int RPT_W     = 32,
  parameter int RST_PULSE = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable_i,
  input  logic [NUM_IDX-1:0]  idx_block_i,
  input  logic [NUM_PROC-1:0] proc_idle_i,
  input  logic [NUM_PROC-1:0] proc_chan_block_i,
  input  logic [CNT_W-1:0]    hold_cycles_i,
  pfb_deadlock_watchdog_ctrl_if.master rpt_if,
  output logic                irq_o,
  input  logic                clr_i,
  input  logic                clr_recover_i,
  output logic                recover_rst_o,
  output logic [7:0]          trip_count_o
);

  localparam int SNAP_W  = NUM_IDX + 2 * NUM_PROC;
  localparam int PULSE_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  state_e             state_q;
  logic               rpt_valid_q;
  logic [RPT_W-1:0]   rpt_data_q;
  logic               irq_q;
  logic               recover_q;
  logic [PULSE_W-1:0] pulse_q;
  logic [7:0]         trip_cnt_q;
  logic [SNAP_W-1:0]  snap_now;
  logic               any_blk;
  logic               trip;

  assign any_blk  = |idx_block_i;
  assign snap_now = {idx_block_i, proc_idle_i, proc_chan_block_i};

  pfb_deadlock_persist_cnt #(
    .CNT_W (CNT_W)
  ) u_persist (
    .clock    (clock),
    .reset_n  (reset_n),
    .active_i (state_q == ARMED && enable_i),
    .blk_i    (any_blk),
    .hold_i   (hold_cycles_i),
    .trip_o   (trip)
  );

`ifdef PFB_DEADLOCK_TIMESTAMP_EN
  // Timestamp equals the number of rising edges since reset release, sampled in the trip cycle.
  logic [31:0] ts_q;
  logic [31:0] ts_snap_q;
  logic        beat_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rpt_valid_q <= 1'b0;
      rpt_data_q  <= '0;
      irq_q       <= 1'b0;
      recover_q   <= 1'b0;
      pulse_q     <= '0;
      trip_cnt_q  <= '0;
`ifdef PFB_DEADLOCK_TIMESTAMP_EN
      ts_snap_q   <= '0;
      beat_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_i) state_q <= ARMED;
        end
        ARMED: begin
          if (!enable_i) begin
            state_q <= IDLE;
          end else if (trip) begin
            state_q     <= REPORT;
            rpt_valid_q <= 1'b1;
            rpt_data_q  <= RPT_W'(snap_now);
            if (trip_cnt_q != TRIP_CNT_MAX) trip_cnt_q <= trip_cnt_q + 8'd1;
`ifdef PFB_DEADLOCK_TIMESTAMP_EN
            ts_snap_q   <= ts_q;
            beat_q      <= 1'b0;
`endif
          end
        end
        REPORT: begin
          if (rpt_if.rpt_ready) begin
`ifdef PFB_DEADLOCK_TIMESTAMP_EN
            if (!beat_q) begin
              beat_q     <= 1'b1;
              rpt_data_q <= RPT_W'(ts_snap_q);
            end else begin
              rpt_valid_q <= 1'b0;
              irq_q       <= 1'b1;
              state_q     <= WAIT_CLR;
            end
`else
            rpt_valid_q <= 1'b0;
            irq_q       <= 1'b1;
            state_q     <= WAIT_CLR;
`endif
          end
        end
        WAIT_CLR: begin
          if (clr_i) begin
            irq_q <= 1'b0;
            if (clr_recover_i) begin
              state_q   <= RECOVER;
              recover_q <= 1'b1;
              pulse_q   <= PULSE_W'(RST_PULSE - 1);
            end else begin
              state_q <= IDLE;
            end
          end
        end
        RECOVER: begin
          if (pulse_q == '0) begin
            recover_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            pulse_q <= pulse_q - PULSE_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rpt_if.rpt_valid = rpt_valid_q;
  assign rpt_if.rpt_data  = rpt_data_q;
  assign irq_o            = irq_q;
  assign recover_rst_o    = recover_q;
  assign trip_count_o     = trip_cnt_q;

endmodule

// File: tb/tb_pfb_deadlock_watchdog_ctrl.sv
// Directed bench for pfb_deadlock_watchdog_ctrl; covers both PFB_DEADLOCK_TIMESTAMP_EN builds.
module tb_pfb_deadlock_watchdog_ctrl;

`ifdef PFB_DEADLOCK_TIMESTAMP_EN
  localparam int BEATS = 2;
`else
  localparam int BEATS = 1;
`endif

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [2:0]  idx_block;
  logic [2:0]  proc_idle;
  logic [2:0]  proc_chan_block;
  logic [15:0] hold_cycles;
  logic        irq;
  logic        clr;
  logic        clr_recover;
  logic        recover_rst;
  logic [7:0]  trip_count;

  int n_chk  = 0;
  int n_fail = 0;
  int unsigned cyc;

  pfb_deadlock_watchdog_ctrl_if #(.RPT_W(32)) rpt_bus ();

  pfb_deadlock_watchdog_ctrl dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .enable_i          (enable),
    .idx_block_i       (idx_block),
    .proc_idle_i       (proc_idle),
    .proc_chan_block_i (proc_chan_block),
    .hold_cycles_i     (hold_cycles),
    .rpt_if            (rpt_bus.master),
    .irq_o             (irq),
    .clr_i             (clr),
    .clr_recover_i     (clr_recover),
    .recover_rst_o     (recover_rst),
    .trip_count_o      (trip_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  typedef struct {
    logic        en;
    logic [2:0]  idx;
    logic [15:0] hold;
    logic        rdy;
    logic        clr;
    logic        crec;
    logic        ev;
    logic [31:0] ed;
    logic        ei;
    logic        er;
    logic [7:0]  etc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic en, logic [2:0] idx, logic [15:0] hold, logic rdy,
                              logic c, logic cr, logic ev, logic [31:0] ed, logic ei,
                              logic er, logic [7:0] etc);
    vec_t v;
    v.en = en; v.idx = idx; v.hold = hold; v.rdy = rdy; v.clr = c; v.crec = cr;
    v.ev = ev; v.ed = ed; v.ei = ei; v.er = er; v.etc = etc;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept any outstanding report and clear the IRQ without recovery.
  task automatic drain_and_clear();
    rpt_bus.rpt_ready = 1'b1;
    for (int i = 0; i < 8 && rpt_bus.rpt_valid; i++) tick();
    rpt_bus.rpt_ready = 1'b0;
    check("drain_done", {31'd0, rpt_bus.rpt_valid}, 32'd0);
    clr = 1'b1; clr_recover = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  task automatic trip_hold1(input logic recover);
    enable = 1'b1; idx_block = 3'b000; tick();
    idx_block = 3'b001; tick();
    idx_block = 3'b000; enable = 1'b0;
    check("trip_valid", {31'd0, rpt_bus.rpt_valid}, 32'd1);
    rpt_bus.rpt_ready = 1'b1;
    for (int b = 0; b < BEATS; b++) tick();
    rpt_bus.rpt_ready = 1'b0;
    clr = 1'b1; clr_recover = recover; tick();
    clr = 1'b0; clr_recover = 1'b0;
  endtask

  initial begin
    int hi_cnt;
    int found;
    reset_n = 1'b0; enable = 1'b0; idx_block = '0; proc_idle = 3'b101;
    proc_chan_block = 3'b011; hold_cycles = 16'd4; clr = 1'b0; clr_recover = 1'b0;
    rpt_bus.rpt_ready = 1'b0;
    tick();
    check("rst_valid", {31'd0, rpt_bus.rpt_valid}, 32'd0);
    check("rst_irq",   {31'd0, irq}, 32'd0);
    check("rst_rec",   {31'd0, recover_rst}, 32'd0);
    check("rst_tc",    {24'd0, trip_count}, 32'd0);
    tick();
    reset_n = 1'b1;

    // Trip, clr ignored in REPORT, glitch, second trip.
    vecs.push_back(mk(1, 3'b000, 4, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b010, 4, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b010, 4, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b010, 4, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b010, 4, 0, 0, 0, 1, 32'h0AB, 0, 0, 1));
    vecs.push_back(mk(1, 3'b000, 4, 0, 0, 0, 1, 32'h0AB, 0, 0, 1));
    vecs.push_back(mk(0, 3'b111, 4, 0, 1, 1, 1, 32'h0AB, 0, 0, 1));
`ifndef PFB_DEADLOCK_TIMESTAMP_EN
    vecs.push_back(mk(1, 3'b000, 4, 1, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 3'b111, 4, 0, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 3'b000, 4, 0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 3'b000, 4, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 3'b001, 4, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 3'b000, 4, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 3'b001, 4, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 3'b001, 4, 0, 0, 0, 1, 32'h06B, 0, 0, 2));
    vecs.push_back(mk(1, 3'b000, 4, 1, 0, 0, 0, 0, 1, 0, 2));
`endif
    foreach (vecs[i]) begin
      enable = vecs[i].en; idx_block = vecs[i].idx; hold_cycles = vecs[i].hold;
      rpt_bus.rpt_ready = vecs[i].rdy; clr = vecs[i].clr; clr_recover = vecs[i].crec;
      tick();
      check($sformatf("vec%0d_valid", i), {31'd0, rpt_bus.rpt_valid}, {31'd0, vecs[i].ev});
      if (vecs[i].ev) check($sformatf("vec%0d_data", i), rpt_bus.rpt_data, vecs[i].ed);
      check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].ei});
      check($sformatf("vec%0d_rec", i), {31'd0, recover_rst}, {31'd0, vecs[i].er});
      check($sformatf("vec%0d_tc", i), {24'd0, trip_count}, {24'd0, vecs[i].etc});
    end
    clr = 1'b0; clr_recover = 1'b0;
    drain_and_clear();

    // Backpressure, then recovery pulse length.
    hold_cycles = 16'd2; enable = 1'b1; idx_block = 3'b000; tick();
    idx_block = 3'b100; tick();
    tick();
    check("bp_trip_valid", {31'd0, rpt_bus.rpt_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      idx_block = 3'(i); clr = i[0]; clr_recover = 1'b1;
      tick();
      check($sformatf("bp%0d_valid", i), {31'd0, rpt_bus.rpt_valid}, 32'd1);
      check($sformatf("bp%0d_data", i), rpt_bus.rpt_data, 32'h12B);
      check($sformatf("bp%0d_irq", i), {31'd0, irq}, 32'd0);
      check($sformatf("bp%0d_rec", i), {31'd0, recover_rst}, 32'd0);
    end
    clr = 1'b0; clr_recover = 1'b0; enable = 1'b0; idx_block = 3'b111;
    rpt_bus.rpt_ready = 1'b1;
    for (int b = 0; b < BEATS; b++) tick();
    rpt_bus.rpt_ready = 1'b0;
    check("bp_irq_after", {31'd0, irq}, 32'd1);
    check("bp_valid_after", {31'd0, rpt_bus.rpt_valid}, 32'd0);
    clr = 1'b1; clr_recover = 1'b1; tick();
    clr = 1'b0; clr_recover = 1'b0;
    check("rec_irq_drop", {31'd0, irq}, 32'd0);
    hi_cnt = recover_rst ? 1 : 0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!recover_rst) begin found = 1; break; end
      hi_cnt++;
    end
    check("rec_pulse_ended", found, 1);
    check("rec_pulse_len", hi_cnt, 16);
    check("rec_idle_irq", {31'd0, irq}, 32'd0);
    check("rec_idle_valid", {31'd0, rpt_bus.rpt_valid}, 32'd0);

    // hold_cycles=0 trips on a single block cycle.
    hold_cycles = 16'd0; enable = 1'b1; idx_block = 3'b000; tick();
    idx_block = 3'b010; tick();
    check("hold0_valid", {31'd0, rpt_bus.rpt_valid}, 32'd1);
    check("hold0_data", rpt_bus.rpt_data, 32'h0AB);
    enable = 1'b0; idx_block = 3'b000;
    drain_and_clear();

    // Saturation from a fresh reset.
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    hold_cycles = 16'd1;
    for (int i = 0; i < 300; i++) begin
      trip_hold1(1'b0);
      if (i == 253) check("tc_254", {24'd0, trip_count}, 32'd254);
    end
    check("tc_sat", {24'd0, trip_count}, 32'd255);

    // Asynchronous reset while the recovery pulse is active.
    trip_hold1(1'b1);
    tick(); tick();
    check("rec_mid_high", {31'd0, recover_rst}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rec", {31'd0, recover_rst}, 32'd0);
    check("async_tc", {24'd0, trip_count}, 32'd0);
    check("async_irq", {31'd0, irq}, 32'd0);
    tick(); tick();
    reset_n = 1'b1;

`ifdef PFB_DEADLOCK_TIMESTAMP_EN
    enable = 1'b1; hold_cycles = 16'd1; idx_block = 3'b000;
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      if (cyc == 1000) begin found = 1; break; end
      tick();
    end
    check("ts_reach_1000", found, 1);
    idx_block = 3'b010; tick();
    idx_block = 3'b000;
    check("ts_beat0_valid", {31'd0, rpt_bus.rpt_valid}, 32'd1);
    check("ts_beat0_data", rpt_bus.rpt_data, 32'h0AB);
    rpt_bus.rpt_ready = 1'b1; tick();
    check("ts_beat1_valid", {31'd0, rpt_bus.rpt_valid}, 32'd1);
    check("ts_beat1_data", rpt_bus.rpt_data, 32'd1000);
    check("ts_beat1_irq", {31'd0, irq}, 32'd0);
    tick();
    rpt_bus.rpt_ready = 1'b0;
    check("ts_irq", {31'd0, irq}, 32'd1);
    check("ts_done_valid", {31'd0, rpt_bus.rpt_valid}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
